// File: rtl/fm_base_feeder.sv
// Feeds 2-bit bases from a small word FIFO into a double-buffered fragment memory,
// one base per cycle, and hands completed 32-base buffers to a downstream consumer.
module fm_base_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [1:0]  fm_wdata,
  output logic        fm_chg_idx,
  input  logic        fm_wait,
  output logic        rd_valid,
  input  logic        rd_done,
  output logic [7:0]  swap_cnt,
  output logic        err_desync
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST  = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {PRIME, FILL, HOLD} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [4:0]    r_mirror;
  logic          r_released, r_rd_valid, r_err;
  logic [7:0]    r_swap_cnt;
  logic          w_push, w_pop, w_chg, w_swap, w_at_top;
  logic [31:0]   w_head;

  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign w_head     = r_mem[r_rd_ptr];
  assign w_at_top   = (r_mirror == 5'd31);
  assign in_ready   = (r_count < DEPTH);
  assign w_push     = in_valid && in_ready;
  assign fm_chg_idx = w_chg;
  assign rd_valid   = r_rd_valid;
  assign swap_cnt   = r_swap_cnt;
  assign err_desync = r_err;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= nxt_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= nxt_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // The head word always holds the bases for the current address; the first
  // word of a buffer pops at address 15, the second when the buffer is swapped.
  always_comb begin
    w_state_nxt = r_state;
    fm_wdata    = 2'b00;
    w_chg       = 1'b0;
    w_pop       = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      PRIME: begin
        if (w_at_top && r_count >= CW'(2)) begin
          w_chg       = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        fm_wdata = w_head[{r_mirror[3:0], 1'b0} +: 2];
        w_pop    = (r_mirror == 5'd15);
        if (r_mirror == 5'd30) w_state_nxt = HOLD;
      end
      HOLD: begin
        fm_wdata = w_head[31:30];
        // Need the word being finished plus two for the next buffer.
        if (r_released && r_count >= CW'(3)) begin
          w_chg       = 1'b1;
          w_pop       = 1'b1;
          w_swap      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PRIME;
      r_mirror   <= '0;
      r_released <= 1'b0;
      r_rd_valid <= 1'b0;
      r_swap_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_chg)          r_mirror <= '0;
      else if (!w_at_top) r_mirror <= r_mirror + 5'd1;
      // A publishing swap wins over a coincident release.
      if (w_swap) begin
        r_rd_valid <= 1'b1;
        r_released <= 1'b0;
        r_swap_cnt <= r_swap_cnt + 8'd1;
      end else if (w_chg) begin
        r_released <= 1'b1;
      end else if (rd_done && r_rd_valid) begin
        r_rd_valid <= 1'b0;
        r_released <= 1'b1;
      end
      if (fm_wait != (w_at_top && !w_chg)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fm_base_feeder.sv
// Bench for fm_base_feeder: a fragment-memory model collects written bases and a
// scoreboard compares each published buffer against the word pairs pushed in.
module tb_fm_base_feeder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, tb_done, cons_done, hold_off, force_wait;
  logic [31:0] in_data;
  logic        in_ready, fm_chg_idx, fm_wait, rd_valid, rd_done, err_desync;
  logic [1:0]  fm_wdata;
  logic [7:0]  swap_cnt;

  fm_base_feeder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fm_wdata(fm_wdata), .fm_chg_idx(fm_chg_idx),
    .fm_wait(fm_wait), .rd_valid(rd_valid), .rd_done(rd_done),
    .swap_cnt(swap_cnt), .err_desync(err_desync)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [63:0] exp_q [$];
  logic [31:0] half_w;
  logic        half_v;
  logic [31:0] w [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Fragment-memory model: its own write address, and the hold it reports.
  logic [1:0] fm_buf [32];
  logic [4:0] fm_addr, fm_addr_nxt;
  int         cyc, chg_seen, pub_seen;
  logic       post_chk, post_rdv;

  assign fm_wait = force_wait | (fm_addr == 5'd31 && !fm_chg_idx);
  assign rd_done = cons_done | tb_done;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) fm_addr <= 5'd0;
    else        fm_addr <= fm_addr_nxt;

  always @(negedge clk) begin
    logic [63:0] got, exp;
    if (!rst_n) begin
      cyc = 0; chg_seen = 0; pub_seen = 0; post_chk = 1'b0; fm_addr_nxt = 5'd0;
    end else begin
      if (post_chk) begin
        chk("post_swap_rd_valid", 64'(rd_valid), 64'(post_rdv));
        chk("post_swap_swap_cnt", 64'(swap_cnt), 64'(pub_seen[7:0]));
        post_chk = 1'b0;
      end
      fm_buf[fm_addr] = fm_wdata;
      if (fm_chg_idx) begin
        if (chg_seen == 0) begin
          chk("prime_swap_cycle", 64'(cyc), 64'(31));
          post_rdv = 1'b0;
        end else begin
          pub_seen++;
          post_rdv = 1'b1;
          for (int k = 0; k < 32; k++) got[2*k +: 2] = fm_buf[k];
          if (exp_q.size() == 0) chk("unexpected_swap", got, 64'(0));
          else begin
            exp = exp_q.pop_front();
            chk("published_buffer", got, exp);
          end
        end
        post_chk = 1'b1;
        chg_seen++;
        fm_addr_nxt = 5'd0;
      end else begin
        fm_addr_nxt = (fm_addr == 5'd31) ? 5'd31 : fm_addr + 5'd1;
      end
      cyc++;
    end
  end

  // Consumer releases each published buffer at once unless told to hold off.
  initial begin
    cons_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid && !hold_off) begin
        cons_done = 1'b1;
        @(negedge clk);
        cons_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 for word %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (half_v) begin exp_q.push_back({d, half_w}); half_v = 1'b0; end
    else begin half_w = d; half_v = 1'b1; end
  endtask

  task automatic wait_swaps(input int n, input int budget);
    int t = 0;
    while (pub_seen < n && t < budget) begin @(posedge clk); #1; t++; end
    chk("swap_reached", 64'(pub_seen >= n), 64'(1));
  endtask

  task automatic reset_checks();
    chk("rst_in_ready",   64'(in_ready),   64'(1));
    chk("rst_rd_valid",   64'(rd_valid),   64'(0));
    chk("rst_swap_cnt",   64'(swap_cnt),   64'(0));
    chk("rst_err_desync", 64'(err_desync), 64'(0));
    chk("rst_fm_chg_idx", 64'(fm_chg_idx), 64'(0));
    chk("rst_fm_wdata",   64'(fm_wdata),   64'(0));
  endtask

  initial begin
    int ir_hi, chg_hi, wd_bad, rdv_lo;
    w = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
          32'hA5A5_5A5A, 32'h3C3C_C3C3, 32'hDEAD_BEEF, 32'hCAFE_F00D,
          32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0, 32'hE1E1_1E1E,
          32'h9669_6996, 32'h5555_AAAA, 32'h0000_FFFF, 32'hFFFF_0000};
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; tb_done = 1'b0;
    hold_off = 1'b0; force_wait = 1'b0; half_v = 1'b0; half_w = '0;
    #3 rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Prime then continuous stream A..F: buffers {B,A}, {D,C} get published.
    for (int i = 0; i < 6; i++) push_word(w[i]);
    wait_swaps(2, 200);
    cycles(5);
    chk("consumed_rd_valid", 64'(rd_valid), 64'(0));

    // Backpressure: {F,E} published but withheld while the FIFO fills.
    hold_off = 1'b1;
    push_word(w[6]); push_word(w[7]);
    wait_swaps(3, 100);
    for (int i = 8; i < 11; i++) push_word(w[i]);
    cycles(20);
    in_valid = 1'b1; in_data = w[11];
    ir_hi = 0; chg_hi = 0; wd_bad = 0; rdv_lo = 0;
    repeat (50) begin
      @(negedge clk);
      if (in_ready) ir_hi++;
      if (fm_chg_idx) chg_hi++;
      if (fm_wdata !== w[7][31:30]) wd_bad++;
      if (!rd_valid) rdv_lo++;
    end
    @(posedge clk); #1;
    chk("bp_in_ready_high_cycles", 64'(ir_hi), 64'(0));
    chk("bp_chg_idx_cycles",       64'(chg_hi), 64'(0));
    chk("bp_wdata_bad_cycles",     64'(wd_bad), 64'(0));
    chk("bp_rd_valid_low_cycles",  64'(rdv_lo), 64'(0));
    hold_off = 1'b0;
    push_word(w[11]);
    wait_swaps(5, 200);
    cycles(40);

    // Starvation: released with only two words, swap follows the third push.
    hold_off = 1'b1;
    push_word(w[12]);
    chg_hi = 0;
    repeat (10) begin @(negedge clk); if (fm_chg_idx) chg_hi++; end
    @(posedge clk); #1;
    chk("starve_no_swap", 64'(chg_hi), 64'(0));
    push_word(w[13]);
    // Coincident rd_done in the swap cycle.
    tb_done = 1'b1;
    @(negedge clk);
    chk("starve_swap_push_plus1", 64'(fm_chg_idx), 64'(1));
    @(posedge clk); #1 tb_done = 1'b0;
    @(negedge clk);
    chk("coincident_rd_valid", 64'(rd_valid), 64'(1));
    @(posedge clk); #1;
    push_word(w[14]); push_word(w[15]);
    chg_hi = 0; rdv_lo = 0;
    repeat (60) begin
      @(negedge clk);
      if (fm_chg_idx) chg_hi++;
      if (!rd_valid) rdv_lo++;
    end
    @(posedge clk); #1;
    chk("coincident_not_released", 64'(chg_hi), 64'(0));
    chk("coincident_rd_valid_held", 64'(rdv_lo), 64'(0));
    hold_off = 1'b0;
    wait_swaps(7, 50);

    // Reset mid-fill, then a forced desync.
    cycles(5);
    chk("no_false_desync", 64'(err_desync), 64'(0));
    rst_n = 1'b0;
    #1 reset_checks();
    exp_q.delete(); half_v = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(10);
    force_wait = 1'b1;
    @(negedge clk);
    chk("desync_before", 64'(err_desync), 64'(0));
    @(posedge clk); #1 force_wait = 1'b0;
    @(negedge clk);
    chk("desync_set", 64'(err_desync), 64'(1));
    cycles(30);
    @(negedge clk);
    chk("desync_sticky", 64'(err_desync), 64'(1));
    chk("fifo_discarded_no_swap", 64'(fm_chg_idx), 64'(0));
    chk("fifo_discarded_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b0;
    #1 chk("desync_cleared", 64'(err_desync), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fm_base_feeder.md
FM_BASE_FEEDER -- requirements
Module: fm_base_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input word FIFO depth in 32-bit words; legal values 3..8.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  32  16 packed 2-bit bases; base j in bits [2j+1:2j].
REQ-006 in_ready  output  1  word accepted when in_valid && in_ready.
REQ-007 fm_wdata  output  2  base written by the fragment memory this cycle.
REQ-008 fm_chg_idx  output  1  buffer swap request to the fragment memory.
REQ-009 fm_wait  input  1  hold indication from the fragment memory.
REQ-010 rd_valid  output  1  fragment-memory read buffer holds a complete valid 32-base buffer.
REQ-011 rd_done  input  1  single-cycle pulse; consumer releases the read buffer.
REQ-012 swap_cnt  output  8  count of valid buffers published, wraps at 255->0.
REQ-013 err_desync  output  1  sticky; fm_wait disagreed with the internal write-address mirror.

Function
REQ-014 The block SHALL keep a 5-bit mirror of the fragment-memory write address: 0 after reset, +1 per cycle while below 31, held at 31 until a cycle with fm_chg_idx=1, then 0 the next cycle.
REQ-015 The FIFO SHALL push on in_valid && in_ready; in_ready = (count < FIFO_DEPTH), with no push-through when full.
REQ-016 FSM states: PRIME (reset state), FILL, HOLD.
REQ-017 PRIME: fm_wdata=0; fm_chg_idx=1 only when mirror==31 && count>=2; transition to FILL; the swapped-in buffer is garbage, so rd_valid stays 0 and the internal released flag is set to 1.
REQ-018 FILL: fm_wdata = base (mirror mod 16) of the FIFO head word for mirror 0..15, and of head+1 for mirror 16..30; the head word pops in the cycle mirror==15; on mirror==30 transition to HOLD.
REQ-019 HOLD (mirror==31): fm_wdata = base 15 of the head word; fm_chg_idx=1 only when released==1 && count>=3; in that cycle pop the head, assert rd_valid from the next cycle, clear released, increment swap_cnt, and transition to FILL.
REQ-020 FILL entry is guaranteed to have 2 words present, so underflow during FILL SHALL be impossible; no other state pops.
REQ-021 rd_done SHALL set released and clear rd_valid next cycle; rd_done while rd_valid==0 SHALL be ignored.
REQ-022 A swap and rd_done in the same cycle SHALL leave released=0 and rd_valid=1, with the swap taking priority.
REQ-023 fm_wdata and fm_chg_idx SHALL be combinational from registered state, the FIFO head and mirror, so the fragment memory writes base k of a buffer at address k.
REQ-024 err_desync SHALL be set when fm_wait != (mirror==31 && !fm_chg_idx); it is cleared only by reset.

Reset
REQ-025 On rst_n low, immediately: state=PRIME, mirror=0, FIFO empty, released=0, rd_valid=0, swap_cnt=0, err_desync=0, fm_chg_idx=0, fm_wdata=0, in_ready=1.
REQ-026 Reset mid-FILL or mid-HOLD SHALL discard all FIFO contents and require the fragment memory to be reset in the same cycle.

Verification
REQ-027 Prime: reset, push words A,B by cycle 5 -> first fm_chg_idx at cycle 31, rd_valid stays 0, FILL emits A base0 at mirror 0.
REQ-028 Full buffer: continuous words A..F -> fm_wdata sequence equals A bases 0-15 then B bases 0-15 at addresses 0..31; first real swap sets rd_valid=1 and swap_cnt=1.
REQ-029 Backpressure: consumer withholds rd_done for 50 cycles -> HOLD persists, fm_chg_idx=0, fm_wdata stays at B base15, FIFO fills to 4 words, in_ready=0, no word lost.
REQ-030 Starvation: released=1 with only 2 words in the FIFO -> no swap until the third word is pushed; swap occurs in the push+1 cycle.
REQ-031 Coincident events: rd_done pulse in the swap cycle -> rd_valid=1 and released=0 afterwards.
REQ-032 Desync: force fm_wait=1 at mirror 10 -> err_desync=1 next cycle and stays 1 until reset.
